// File: rtl/symmetric_fir_mac.sv
// Linear-phase FIR with one sequential MAC: pre-adds mirrored taps, accumulates NTAPS/2 products,
// then rounds half toward +inf, shifts and saturates the result to DW bits.
module symmetric_fir_mac #(
   parameter int unsigned NTAPS = 128,
   parameter int unsigned DW    = 16,
   parameter int unsigned CW    = 36,
   parameter int unsigned SHIFT = 34,
   parameter int unsigned AW    = $clog2(NTAPS/2)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          din_enable,
   input  logic [DW-1:0] datain,
   input  logic          flush,
   input  logic [CW-1:0] coeff,
   output logic [AW-1:0] coeffaddress,
   output logic [DW-1:0] dataout,
   output logic          dout_valid,
   output logic          busy,
   output logic          sat,
   output logic          overrun
);

   localparam int unsigned H    = NTAPS / 2;
   localparam int unsigned IW   = $clog2(NTAPS);
   localparam int unsigned PAW  = DW + 1;
   localparam int unsigned PW   = DW + 1 + CW;
   localparam int unsigned ACCW = PW + $clog2(H);
   localparam int unsigned RW   = ACCW + 1;

   localparam logic signed [RW-1:0] RND  = (RW'(1) << SHIFT) >> 1;
   localparam logic signed [RW-1:0] OMAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_t;

   state_t                 state, state_nxt;
   logic signed [DW-1:0]   win [NTAPS];
   logic signed [ACCW-1:0] acc;

   logic                   accept_c, drop_c, last_c, sat_c;
   logic [IW-1:0]          lo_idx_c, hi_idx_c;
   logic signed [PAW-1:0]  pre_c;
   logic signed [PW-1:0]   prod_c;
   logic signed [RW-1:0]   sum_c, rnd_c;
   logic [DW-1:0]          clip_c;

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and sample accept/drop qualification
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      drop_c    = 1'b0;
      last_c    = (coeffaddress == AW'(H-1));
      unique case (state)
         ST_IDLE: begin
            if (!flush && din_enable) begin
               accept_c  = 1'b1;
               state_nxt = ST_MAC;
            end
         end
         ST_MAC: begin
            drop_c = din_enable;
            if (last_c) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            drop_c    = din_enable;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Mirrored-tap pre-add, product, rounding and clip
   always_comb begin
      lo_idx_c = IW'(coeffaddress);
      hi_idx_c = IW'(NTAPS-1) - lo_idx_c;
      pre_c    = PAW'(win[lo_idx_c]) + PAW'(win[hi_idx_c]);
      prod_c   = PW'(pre_c) * PW'(signed'(coeff));
      sum_c    = RW'(acc) + RND;
      rnd_c    = sum_c >>> SHIFT;
      sat_c    = 1'b0;
      clip_c   = rnd_c[DW-1:0];
      if (rnd_c > OMAX) begin
         clip_c = OMAX[DW-1:0];
         sat_c  = 1'b1;
      end else if (rnd_c < OMIN) begin
         clip_c = OMIN[DW-1:0];
         sat_c  = 1'b1;
      end
   end

   // Window, accumulator and registered outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NTAPS; i++) win[IW'(i)] <= '0;
         acc          <= '0;
         coeffaddress <= '0;
         dataout      <= '0;
         dout_valid   <= 1'b0;
         busy         <= 1'b0;
         sat          <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         busy       <= (state_nxt != ST_IDLE);
         if (drop_c) overrun <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               coeffaddress <= '0;
               if (flush) begin
                  for (int i = 0; i < NTAPS; i++) win[IW'(i)] <= '0;
               end else if (accept_c) begin
                  for (int i = NTAPS-1; i > 0; i--) win[IW'(i)] <= win[IW'(i-1)];
                  win[0] <= signed'(datain);
                  acc    <= '0;
               end
            end
            ST_MAC: begin
               acc          <= acc + ACCW'(prod_c);
               coeffaddress <= last_c ? '0 : coeffaddress + AW'(1);
            end
            ST_DONE: begin
               dataout    <= clip_c;
               sat        <= sat_c;
               dout_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_symmetric_fir_mac.sv
// Bench for symmetric_fir_mac: two instances (SHIFT=0 and SHIFT=2) share stimulus and are
// compared against a direct-form FIR reference built from the full symmetric coefficient set.
module tb_symmetric_fir_mac;
   localparam int unsigned NT = 8;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 36;
   localparam int unsigned AW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          din_enable = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] datain = '0;
   logic [CW-1:0] coeff0, coeff2;
   logic [AW-1:0] addr0, addr2;
   logic [DW-1:0] dout0, dout2;
   logic          dv0, dv2, busy0, busy2, sat0, sat2, ov0, ov2;

   longint rom [4];
   longint hist [NT];
   bit     ov_exp;
   int     n_cmp = 0;
   int     n_bad = 0;

   always #5 clock = ~clock;

   assign coeff0 = CW'(rom[addr0]);
   assign coeff2 = CW'(rom[addr2]);

   symmetric_fir_mac #(.NTAPS(NT), .DW(DW), .CW(CW), .SHIFT(0), .AW(AW)) dut0 (
      .clock(clock), .reset(reset), .din_enable(din_enable), .datain(datain), .flush(flush),
      .coeff(coeff0), .coeffaddress(addr0), .dataout(dout0), .dout_valid(dv0), .busy(busy0),
      .sat(sat0), .overrun(ov0));

   symmetric_fir_mac #(.NTAPS(NT), .DW(DW), .CW(CW), .SHIFT(2), .AW(AW)) dut2 (
      .clock(clock), .reset(reset), .din_enable(din_enable), .datain(datain), .flush(flush),
      .coeff(coeff2), .coeffaddress(addr2), .dataout(dout2), .dout_valid(dv2), .busy(busy2),
      .sat(sat2), .overrun(ov2));

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // y = sum_j c_full[j] * x[j], with c_full the mirrored ROM contents
   function automatic longint ref_out(input int sh, output bit s);
      longint a, r;
      a = 0;
      for (int j = 0; j < NT; j++) a += rom[(j < 4) ? j : NT-1-j] * hist[j];
      if (sh > 0) a += longint'(1) << (sh - 1);
      r = a >>> sh;
      s = (r > 32767) || (r < -32768);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   task automatic clear_hist();
      for (int j = 0; j < NT; j++) hist[j] = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      clear_hist();
      ov_exp = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      clear_hist();
   endtask

   // Offer one sample, optionally inject a dropped strobe drop_at cycles after the accept
   task automatic send(input logic signed [15:0] v, input int drop_at);
      bit     got, s0, s2;
      longint e0, e2;
      @(negedge clock);
      din_enable = 1'b1;
      datain     = v;
      @(negedge clock);
      din_enable = 1'b0;
      for (int j = NT-1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = longint'(v);
      e0 = ref_out(0, s0);
      e2 = ref_out(2, s2);
      if (drop_at >= 0) ov_exp = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (i > 0) @(negedge clock);
         if (i <= 5) begin
            check("coeffaddress", addr0, (i < 4) ? i : 0);
            check("busy", busy0, (i <= 4) ? 1 : 0);
            check("dout_valid", dv0, (i == 5) ? 1 : 0);
         end
         if (dv0) begin
            got = 1'b1;
            check("dout_valid_s2", dv2, 1);
            check("dataout_s0", $signed(dout0), e0);
            check("dataout_s2", $signed(dout2), e2);
            check("sat_s0", sat0, s0);
            check("sat_s2", sat2, s2);
            check("overrun_s0", ov0, ov_exp);
            check("overrun_s2", ov2, ov_exp);
         end
         din_enable = (i == drop_at);
         datain     = DW'($urandom);
      end
      din_enable = 1'b0;
      if (!got) check("timeout_dout_valid", 0, 1);
   endtask

   // Count dout_valid pulses over a window where none should appear
   task automatic quiet(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (dv0 || dv2) pulses++;
      end
      check(tag, pulses, 0);
   endtask

   initial begin
      logic signed [15:0] imp_exp [8];
      logic signed [15:0] rnd_in [4];
      logic signed [15:0] rnd_exp [4];
      imp_exp = '{1, 2, 3, 4, 4, 3, 2, 1};
      rnd_in  = '{2, 1, -2, -3};
      rnd_exp = '{1, 0, 0, -1};
      rom = '{1, 2, 3, 4};
      clear_hist();
      ov_exp = 1'b0;

      repeat (3) @(negedge clock);
      check("rst_dataout", dout0, 0);
      check("rst_dout_valid", dv0, 0);
      check("rst_busy", busy0, 0);
      check("rst_sat", sat0, 0);
      check("rst_overrun", ov0, 0);
      check("rst_coeffaddress", addr0, 0);
      reset = 1'b1;

      // Impulse response, with per-cycle handshake checks inside send
      for (int k = 0; k < 8; k++) begin
         send((k == 0) ? 16'sd1 : 16'sd0, -1);
         check("impulse", $signed(dout0), imp_exp[k]);
         check("impulse_sat", sat0, 0);
      end

      // Dropped strobes during MAC and during the DONE cycle
      do_reset();
      check("overrun_after_reset", ov0, 0);
      for (int k = 0; k < 8; k++) begin
         send((k == 0) ? 16'sd1 : 16'sd0, (k == 0) ? 2 : ((k == 3) ? 4 : -1));
         check("overrun_impulse", $signed(dout0), imp_exp[k]);
      end
      check("overrun_sticky", ov0, 1);

      // Reset during the second MAC cycle aborts the result
      do_reset();
      @(negedge clock);
      din_enable = 1'b1;
      datain     = 16'd9;
      @(negedge clock);
      din_enable = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      quiet("abort_no_valid", 8);
      check("abort_dataout", dout0, 0);
      check("abort_busy", busy0, 0);
      send(16'sd5, -1);
      check("after_abort", $signed(dout0), 5);

      // Flush in IDLE, and flush winning over a simultaneous strobe
      send(16'sd7, -1);
      send(16'sd7, -1);
      do_flush();
      send(16'sd1, -1);
      check("after_flush", $signed(dout0), 1);
      @(negedge clock);
      flush      = 1'b1;
      din_enable = 1'b1;
      datain     = 16'd100;
      @(negedge clock);
      flush      = 1'b0;
      din_enable = 1'b0;
      clear_hist();
      quiet("flush_priority_no_valid", 8);
      check("flush_priority_overrun", ov0, 0);
      send(16'sd0, -1);

      // Saturation at both rails
      rom = '{1000, 1000, 1000, 1000};
      do_reset();
      for (int k = 0; k < 8; k++) send(16'sd32767, -1);
      check("sat_pos_value", $signed(dout0), 32767);
      check("sat_pos_flag", sat0, 1);
      for (int k = 0; k < 8; k++) send(-16'sd32768, -1);
      check("sat_neg_value", $signed(dout0), -32768);
      check("sat_neg_flag", sat0, 1);

      // Round half toward +inf on the SHIFT=2 instance
      rom = '{1, 1, 1, 1};
      for (int k = 0; k < 4; k++) begin
         do_flush();
         send(rnd_in[k], -1);
         check("round_s2", $signed(dout2), rnd_exp[k]);
         check("round_s0", $signed(dout0), rnd_in[k]);
      end

      // Random coefficients, samples, drops and flushes
      do_reset();
      for (int k = 0; k < 4; k++) rom[k] = longint'($urandom_range(0, 6)) - 3;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) do_flush();
         send(16'(int'($urandom_range(0, 65535)) - 32768),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
